// File: rtl/eeprom_ram_bridge.sv
// eeprom_ram_bridge: serves the 24C0x emulator's held read/write requests
// and the host save-file port on one synchronous block RAM, with dirty flag.
// Ports: clk, reset_n (async, active low); eep_read/eep_write/eep_addr/
// eep_wdata -> eep_rdata/eep_done; host_req/host_we/host_addr/host_wdata ->
// host_rdata/host_ack; mem_addr/mem_wdata/mem_we -> RAM, mem_rdata <- RAM;
// dirty/dirty_clr; busy.
// Optional macro EEPROM_BRIDGE_DIRTY_EN builds the dirty register; without
// it dirty is tied low and dirty_clr is ignored.
// mem_rdata is sampled on the RD_LATENCY-th cycle after mem_addr is loaded.
module eeprom_ram_bridge #(
    parameter int RD_LATENCY = 1,
    parameter int ADDR_W     = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              eep_read,
    input  logic              eep_write,
    input  logic [ADDR_W-1:0] eep_addr,
    input  logic [7:0]        eep_wdata,
    output logic [7:0]        eep_rdata,
    output logic              eep_done,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [7:0]        host_wdata,
    output logic [7:0]        host_rdata,
    output logic              host_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    input  logic [7:0]        mem_rdata,
    output logic              dirty,
    input  logic              dirty_clr,
    output logic              busy
);

    typedef enum logic [2:0] {
        IDLE, E_WR, E_RD, E_DONE, H_WR, H_RD, H_DONE
    } state_t;

    localparam logic [1:0] LAST = 2'(RD_LATENCY - 1);

    state_t            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
    logic              mem_we_q, mem_we_d;
    logic [7:0]        eep_rdata_q, eep_rdata_d;
    logic              eep_done_q, eep_done_d;
    logic [7:0]        host_rdata_q, host_rdata_d;
    logic              host_ack_q, host_ack_d;
    logic              eep_srv_q, eep_srv_d;
    logic              host_srv_q, host_srv_d;
    logic              busy_q, busy_d;
    logic              eep_new, host_new;

    // Served flags keep a still-held level from being accepted twice.
    assign eep_new  = (eep_read | eep_write) & ~eep_srv_q;
    assign host_new = host_req & ~host_srv_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_we_d     = 1'b0;
        eep_rdata_d  = eep_rdata_q;
        eep_done_d   = eep_done_q;
        host_rdata_d = host_rdata_q;
        host_ack_d   = host_ack_q;
        eep_srv_d    = eep_srv_q;
        host_srv_d   = host_srv_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = 2'd0;
                if (eep_new) begin
                    mem_addr_d  = eep_addr;
                    mem_wdata_d = eep_wdata;
                    eep_srv_d   = 1'b1;
                    // write wins when both levels are high
                    if (eep_write) begin
                        mem_we_d = 1'b1;
                        state_d  = E_WR;
                    end else begin
                        state_d = E_RD;
                    end
                end else if (host_new) begin
                    mem_addr_d  = host_addr;
                    mem_wdata_d = host_wdata;
                    host_srv_d  = 1'b1;
                    if (host_we) begin
                        mem_we_d = 1'b1;
                        state_d  = H_WR;
                    end else begin
                        state_d = H_RD;
                    end
                end
            end
            E_WR: begin
                eep_done_d = 1'b1;
                state_d    = E_DONE;
            end
            E_RD: begin
                if (cnt_q == LAST) begin
                    eep_rdata_d = mem_rdata;
                    eep_done_d  = 1'b1;
                    state_d     = E_DONE;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            E_DONE: begin
                if (!eep_read && !eep_write) begin
                    eep_done_d = 1'b0;
                    eep_srv_d  = 1'b0;
                    state_d    = IDLE;
                end
            end
            H_WR: begin
                host_ack_d = 1'b1;
                state_d    = H_DONE;
            end
            H_RD: begin
                if (cnt_q == LAST) begin
                    host_rdata_d = mem_rdata;
                    host_ack_d   = 1'b1;
                    state_d      = H_DONE;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            H_DONE: begin
                if (!host_req) begin
                    host_ack_d = 1'b0;
                    host_srv_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cnt_q        <= 2'd0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= 8'h00;
            mem_we_q     <= 1'b0;
            eep_rdata_q  <= 8'h00;
            eep_done_q   <= 1'b0;
            host_rdata_q <= 8'h00;
            host_ack_q   <= 1'b0;
            eep_srv_q    <= 1'b0;
            host_srv_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_we_q     <= mem_we_d;
            eep_rdata_q  <= eep_rdata_d;
            eep_done_q   <= eep_done_d;
            host_rdata_q <= host_rdata_d;
            host_ack_q   <= host_ack_d;
            eep_srv_q    <= eep_srv_d;
            host_srv_q   <= host_srv_d;
            busy_q       <= busy_d;
        end
    end

`ifdef EEPROM_BRIDGE_DIRTY_EN
    logic dirty_q, dirty_d;

    // A write strobe from E_WR beats a coincident clear.
    always_comb begin
        dirty_d = dirty_q;
        if (state_q == E_WR) begin
            dirty_d = 1'b1;
        end else if (dirty_clr) begin
            dirty_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dirty_q <= 1'b0;
        end else begin
            dirty_q <= dirty_d;
        end
    end

    assign dirty = dirty_q;
`else
    logic unused_dirty_clr;
    assign unused_dirty_clr = dirty_clr;
    assign dirty = 1'b0;
`endif

    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_we     = mem_we_q;
    assign eep_rdata  = eep_rdata_q;
    assign eep_done   = eep_done_q;
    assign host_rdata = host_rdata_q;
    assign host_ack   = host_ack_q;
    assign busy       = busy_q;

endmodule
